// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: clears x1..x31 after reset, then round-robin
// arbitrates NREQ write-back requesters onto a3/wd3/we3 and exposes the in-flight write.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      a3,
  output logic [DW-1:0]      wd3,
  output logic               we3,
  output logic               busy,
  output logic               fwd_valid,
  output logic [AW-1:0]      fwd_addr,
  output logic [DW-1:0]      fwd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);
  localparam logic [AW-1:0] LAST_CLR  = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_ptr, clr_ptr_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [AW-1:0]   a3_nxt;
  logic [DW-1:0]   wd3_nxt;
  logic            we3_nxt;

  logic [PW:0]     cand;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            handshake;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Rotating priority search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= NREQ_W)
        cand = cand - NREQ_W;
      if (!grant_any && req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == RUN && grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_ready & req_valid);
  assign sel_addr  = req_addr[grant_idx*AW +: AW];
  assign sel_data  = req_data[grant_idx*DW +: DW];

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    rr_ptr_nxt  = rr_ptr;
    we3_nxt     = 1'b0;
    a3_nxt      = a3;
    wd3_nxt     = wd3;
    case (state)
      CLEAR: begin
        we3_nxt     = 1'b1;
        a3_nxt      = clr_ptr;
        wd3_nxt     = '0;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_CLR)
          state_nxt = RUN;
      end
      RUN: begin
        // x0 writes still consume the grant but never raise the write enable.
        if (handshake) begin
          we3_nxt    = (sel_addr != '0);
          a3_nxt     = sel_addr;
          wd3_nxt    = sel_data;
          rr_ptr_nxt = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= AW'(1);
      rr_ptr  <= '0;
      we3     <= 1'b0;
      a3      <= '0;
      wd3     <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      rr_ptr  <= rr_ptr_nxt;
      we3     <= we3_nxt;
      a3      <= a3_nxt;
      wd3     <= wd3_nxt;
    end
  end

  assign busy      = (state == CLEAR);
  assign fwd_valid = we3 && (a3 != '0);
  assign fwd_addr  = a3;
  assign fwd_data  = wd3;

endmodule
